// File: rtl/ula_nbit.sv
// N-bit ALU with operand gating, output shifter and a one-deep valid/ready result register.
// Computes the combinational result each cycle and registers it with flags on an accepted request.
module ula_nbit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ena,
    input  logic         enb,
    input  logic         inva,
    input  logic [1:0]   f,
    input  logic         cin,
    input  logic         sll8,
    input  logic         sra1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         flag_n,
    output logic         flag_z,
    output logic         flag_c
);

    logic [W-1:0] xa;
    logic [W-1:0] xb;
    logic [W:0]   sum;
    logic [W-1:0] alu;
    logic [W-1:0] shifted;
    logic         carry;
    logic         take_in;
    logic         take_out;

    always_comb begin
        xa      = (ena ? a : '0) ^ {W{inva}};
        xb      = enb ? b : '0;
        sum     = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, cin};
        alu     = '0;
        carry   = 1'b0;
        shifted = '0;
        case (f)
            2'b00: alu = xa & xb;
            2'b01: alu = xa | xb;
            2'b10: alu = ~xb;
            2'b11: begin
                alu   = sum[W-1:0];
                carry = sum[W];
            end
            default: alu = '0;
        endcase
        // Left shift wins when both shifter controls are asserted.
        if (sll8)
            shifted = {alu[W-9:0], 8'h00};
        else if (sra1)
            shifted = {alu[W-1], alu[W-1:1]};
        else
            shifted = alu;
    end

    // Handshake: a transfer happens on a rising edge where valid && ready are both high on
    // that side; in_ready depends only on the output register state, never on in_valid.
    assign in_ready = !out_valid || out_ready;
    assign take_in  = in_valid && in_ready;
    assign take_out = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b1;
            flag_c    <= 1'b0;
        end else begin
            if (take_in) begin
                out_valid <= 1'b1;
                result    <= shifted;
                flag_n    <= shifted[W-1];
                flag_z    <= (shifted == '0);
                flag_c    <= carry;
            end else if (take_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ula_nbit.sv
// Directed bench for ula_nbit: driver pushes hand-computed results into a queue,
// a negedge monitor pops and compares each result as it is transferred out.
module tb_ula_nbit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ena = 1'b0;
    logic         enb = 1'b0;
    logic         inva = 1'b0;
    logic [1:0]   f = 2'b00;
    logic         cin = 1'b0;
    logic         sll8 = 1'b0;
    logic         sra1 = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         flag_n;
    logic         flag_z;
    logic         flag_c;

    logic [W+2:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    ula_nbit #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ena(ena), .enb(enb), .inva(inva), .f(f), .cin(cin),
        .sll8(sll8), .sra1(sra1), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    function automatic logic [W+2:0] pk(input logic [W-1:0] r, input logic n, z, c);
        return {r, n, z, c};
    endfunction

    task automatic check(input string name, input logic [W+2:0] act, input logic [W+2:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tena, input logic tenb, input logic tinva,
                         input logic [1:0] tf, input logic tcin, input logic tsll,
                         input logic tsra, input logic [W+2:0] expv);
        logic got;
        got = 1'b0;
        a = ta; b = tb_v; ena = tena; enb = tenb; inva = tinva;
        f = tf; cin = tcin; sll8 = tsll; sra1 = tsra;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(expv);
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout actual=in_ready_low required=in_ready_high");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%h required=none", result);
                end else begin
                    check("result_flags", pk(result, flag_n, flag_z, flag_c), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {{(W+2){1'b0}}, out_valid}, '0);
        check("rst_result_flags", pk(result, flag_n, flag_z, flag_c), pk('0, 1'b0, 1'b1, 1'b0));
        check("rst_in_ready", {{(W+2){1'b0}}, in_ready}, {{(W+2){1'b0}}, 1'b1});
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        issue(32'd5, 32'd3, 1, 1, 0, 2'b11, 0, 0, 0, pk(32'h0000_0008, 0, 0, 0));
        issue(32'd5, 32'd3, 1, 1, 1, 2'b11, 1, 0, 0, pk(32'hFFFF_FFFE, 1, 0, 0));
        issue(32'd1, 32'd1, 1, 1, 1, 2'b11, 1, 0, 0, pk(32'h0000_0000, 0, 1, 1));
        issue(32'd0, 32'h0000_00FF, 0, 1, 0, 2'b10, 0, 1, 0, pk(32'hFFFF_0000, 1, 0, 0));
        issue(32'h8000_0000, 32'd0, 1, 1, 0, 2'b01, 0, 0, 1, pk(32'hC000_0000, 1, 0, 0));
        issue(32'h0000_0001, 32'd0, 1, 1, 0, 2'b01, 0, 1, 1, pk(32'h0000_0100, 0, 0, 0));
        issue(32'hF0F0_F0F0, 32'hFF00_FF00, 1, 1, 0, 2'b00, 0, 0, 0, pk(32'hF000_F000, 1, 0, 0));
        issue(32'h0000_0010, 32'h0000_0001, 1, 1, 0, 2'b01, 0, 0, 1, pk(32'h0000_0008, 0, 0, 0));
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0, 2'b11, 0, 0, 0, pk(32'hFFFF_FFFF, 1, 0, 0));

        // Result and flags must hold once out_valid has fallen.
        repeat (2) @(negedge clk);
        check("idle_out_valid", {{(W+2){1'b0}}, out_valid}, '0);
        check("idle_hold", pk(result, flag_n, flag_z, flag_c), pk(32'hFFFF_FFFF, 1, 0, 0));
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        issue(32'd7, 32'd9, 1, 1, 0, 2'b11, 0, 0, 0, pk(32'h0000_0010, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            a = 32'h1234_0000 + i; b = 32'h0000_0F0F + i; f = 2'(i); in_valid = 1'b1;
            @(negedge clk);
            check("stall_in_ready", {{(W+2){1'b0}}, in_ready}, '0);
            check("stall_out_valid", {{(W+2){1'b0}}, out_valid}, {{(W+2){1'b0}}, 1'b1});
            check("stall_hold", pk(result, flag_n, flag_z, flag_c), pk(32'h0000_0010, 0, 0, 0));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        issue(32'd2, 32'd2, 1, 1, 0, 2'b11, 1, 0, 0, pk(32'h0000_0005, 0, 0, 0));
        out_ready = 1'b0;
        @(negedge clk);
        check("refill_out_valid", {{(W+2){1'b0}}, out_valid}, {{(W+2){1'b0}}, 1'b1});
        check("refill_result", pk(result, flag_n, flag_z, flag_c), pk(32'h0000_0005, 0, 0, 0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        issue(32'd1, 32'd1, 1, 1, 0, 2'b11, 0, 0, 0, pk(32'h0000_0002, 0, 0, 0));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", {{(W+2){1'b0}}, out_valid}, '0);
        check("midrst_result_flags", pk(result, flag_n, flag_z, flag_c), pk('0, 1'b0, 1'b1, 1'b0));
        check("midrst_in_ready", {{(W+2){1'b0}}, in_ready}, {{(W+2){1'b0}}, 1'b1});

        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("queue_drained", (W+3)'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
